pwm_multi_ramp: RTL and testbench
=================================

Name: pwm_multi_ramp

Overview:
Multi-channel PWM generator and parametrised successor of the single-channel motor-speed PWM. It sits between the ALU/result register and the motor drivers.
- Duty per channel is set from a packed target bus, latched on a load strobe, and applied only at period boundaries, so outputs never glitch.
- Optional soft-start mode slews each channel's duty by one LSB per PWM period toward its target.
- A shared prescaler sets the PWM frequency.

Parameters:
WIDTH, 4, duty resolution in bits; MAX = 2^WIDTH-1 is full-on duty
CHANNELS, 2, number of independent PWM outputs
PRESCALE, 16, clk cycles per PWM counter tick (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  run enable; 0 halts counters and forces outputs low
duty_target  input  CHANNELS*WIDTH  packed target duties, channel i at [i*WIDTH +: WIDTH]
load  input  1  one-clock strobe: capture duty_target into shadow target registers
ramp_en  input  1  1 = slew duty one LSB per period; 0 = jump to target at next boundary
pwm_out  output  CHANNELS  registered PWM outputs
period_start  output  1  one-clock pulse on first clock of each PWM period
busy  output  1  1 while any channel's applied duty differs from its target

Behaviour:
- Reset (async, any time, including mid-period or mid-ramp) clears everything to 0:
  - prescaler, period counter cnt, shadow targets tgt[i], applied duties cur[i]
  - pwm_out, period_start, busy
  - First period after reset release starts with cnt=0.
- Prescaler:
  - pre counts 0..PRESCALE-1 while en=1.
  - tick = (pre==PRESCALE-1); pre wraps to 0 on tick.
  - PRESCALE=1 gives tick every clock.
- Period counter:
  - cnt counts 0..MAX-1 on each tick and wraps to 0.
  - Period length is MAX*PRESCALE clocks (default 240).
  - boundary = tick and cnt==MAX-1.
- Output compare:
  - pwm_out[i] is registered from next-state values.
  - In every clock, pwm_out[i] = en & (cnt < cur[i]) using that clock's registered cnt and cur.
  - cur=0: constant low. cur=MAX: constant high, no one-tick dropout.
  - High time per period is exactly cur[i]*PRESCALE clocks.
- Target load:
  - On load=1, tgt[i] <= duty_target slice i at the clock edge, for all channels.
  - load is accepted regardless of en.
  - Loads mid-period do not affect cur until the next boundary.
- Boundary update, per channel:
  - ramp_en=0: cur[i] <= tgt[i].
  - ramp_en=1: cur[i] <= cur[i]+1 if cur<tgt; cur[i]-1 if cur>tgt; unchanged if equal.
  - Unsigned compare; never overshoots or wraps.
  - A ramp from 0 to MAX therefore completes in MAX boundaries.
- Simultaneous load and boundary: the boundary update uses the old tgt; the new tgt takes effect at the following boundary.
- ramp_en is sampled at each boundary. Toggling it mid-ramp applies from the next boundary.
- period_start:
  - High for exactly one clock, coincident with the first clock where cnt==0 after a boundary.
  - Also high on the first clock after en rises.
- en=0:
  - pre and cnt are held at 0; pwm_out=0; period_start=0.
  - cur and tgt are retained; no boundary updates occur.
  - On en rising, a fresh period starts at cnt=0 using the retained cur.
- busy = OR over i of (cur[i] != tgt[i]), registered. With ramp_en=0 it clears at the first boundary after load.

Test Plan:
- Reset then en=1, load duty_target ch0=0, ch1=15 (default params) -> pwm_out[0] constant 0, pwm_out[1] constant 1 from second period on; period_start every 240 clocks.
- ramp_en=0, load ch0=8 -> from next boundary ch0 high 128 clocks, low 112 clocks per period; busy drops at that boundary.
- ramp_en=1, cur=0, load ch0=15 -> ch0 high time grows 16 clocks per period: 16, 32 … 240. busy stays high for 15 boundaries, then 0. Then load ch0=12 -> three periods of decreasing duty, ending at 192 clocks.
- Load ch0=3 mid-period, then ch0=5 on the exact boundary clock -> next period uses 3 (48 clocks high), the following one uses 5 (80 clocks high).
- Assert rst mid-ramp at cur=7 -> all outputs 0 immediately; after release with en=1 and no load, outputs stay low and busy=0.
- CHANNELS=4, WIDTH=6, PRESCALE=1, load duties 0, 1, 31, 63 -> per 63-clock period, high times 0, 1, 31, 63 clocks, all channels phase-aligned to period_start.

Source files
------------

// File: rtl/pwm_multi_ramp.sv
// Multi-channel PWM with shadowed duty targets applied at period boundaries
// and optional one-LSB-per-period soft-start slewing.
module pwm_ramp_lane #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_tgt,
  input  logic             i_bnd,
  input  logic             i_ramp,
  input  logic [WIDTH-1:0] i_cnt_nxt,
  output logic             o_pwm,
  output logic             o_neq
);
  logic [WIDTH-1:0] r_tgt, r_cur;
  logic [WIDTH-1:0] w_tgt_nxt, w_cur_nxt;
  logic             r_pwm;

  // Boundary update reads the old target, so a load on the boundary clock
  // only takes effect one period later.
  always_comb begin
    w_cur_nxt = r_cur;
    if (i_bnd) begin
      if (!i_ramp)             w_cur_nxt = r_tgt;
      else if (r_cur < r_tgt)  w_cur_nxt = r_cur + 1'b1;
      else if (r_cur > r_tgt)  w_cur_nxt = r_cur - 1'b1;
    end
    w_tgt_nxt = i_load ? i_tgt : r_tgt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tgt <= '0;
      r_cur <= '0;
      r_pwm <= 1'b0;
    end else begin
      r_tgt <= w_tgt_nxt;
      r_cur <= w_cur_nxt;
      r_pwm <= i_en & (i_cnt_nxt < w_cur_nxt);
    end
  end

  assign o_pwm = r_pwm;
  assign o_neq = (w_cur_nxt != w_tgt_nxt);
endmodule

module pwm_multi_ramp #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 2,
  parameter int PRESCALE = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [CHANNELS*WIDTH-1:0] duty_target,
  input  logic                      load,
  input  logic                      ramp_en,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      period_start,
  output logic                      busy
);
  localparam int MAX = (1 << WIDTH) - 1;
  localparam int PW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0]       r_pre, w_pre_nxt;
  logic [WIDTH-1:0]    r_cnt, w_cnt_nxt;
  logic                r_run, r_ps, r_busy;
  logic                w_tick, w_adv, w_bnd;
  logic [CHANNELS-1:0] w_neq;

  // r_run is low on the first enabled clock, which holds cnt at 0 so every
  // run starts with a full first period.
  assign w_tick = (r_pre == PW'(PRESCALE - 1));
  assign w_adv  = en & r_run;
  assign w_bnd  = w_adv & w_tick & (r_cnt == WIDTH'(MAX - 1));

  always_comb begin
    w_pre_nxt = '0;
    w_cnt_nxt = '0;
    if (w_adv) begin
      w_pre_nxt = w_tick ? '0 : r_pre + 1'b1;
      w_cnt_nxt = r_cnt;
      if (w_tick) w_cnt_nxt = w_bnd ? '0 : r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre  <= '0;
      r_cnt  <= '0;
      r_run  <= 1'b0;
      r_ps   <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_pre  <= w_pre_nxt;
      r_cnt  <= w_cnt_nxt;
      r_run  <= en;
      r_ps   <= en & (w_bnd | ~r_run);
      r_busy <= |w_neq;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    pwm_ramp_lane #(.WIDTH(WIDTH)) u_lane (
      .clk       (clk),
      .rst       (rst),
      .i_en      (en),
      .i_load    (load),
      .i_tgt     (duty_target[g*WIDTH +: WIDTH]),
      .i_bnd     (w_bnd),
      .i_ramp    (ramp_en),
      .i_cnt_nxt (w_cnt_nxt),
      .o_pwm     (pwm_out[g]),
      .o_neq     (w_neq[g])
    );
  end

  assign period_start = r_ps;
  assign busy         = r_busy;
endmodule

// File: tb/tb_pwm_multi_ramp.sv
// Randomized bench for pwm_multi_ramp checked against a clock-position model
// of each PWM period.
module tb_pwm_multi_ramp;
  localparam int W   = 4;
  localparam int CH  = 2;
  localparam int PS  = 16;
  localparam int MAX = (1 << W) - 1;
  localparam int PER = MAX * PS;

  logic            clk = 1'b0;
  logic            rst, en, load, ramp_en;
  logic [CH*W-1:0] duty_target;
  logic [CH-1:0]   pwm_out;
  logic            period_start, busy;

  int n_chk = 0;
  int n_err = 0;

  int m_tgt [CH];
  int m_cur [CH];
  int pos;
  bit run;

  pwm_multi_ramp #(.WIDTH(W), .CHANNELS(CH), .PRESCALE(PS)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .duty_target  (duty_target),
    .load         (load),
    .ramp_en      (ramp_en),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_tgt[i] = 0;
      m_cur[i] = 0;
    end
    pos = 0;
    run = 0;
  endtask

  // Clock position inside the period; the period wraps after PER clocks.
  task automatic model_edge();
    if (rst) begin
      model_reset();
      return;
    end
    if (!en) begin
      run = 0;
      pos = 0;
    end else if (!run) begin
      run = 1;
      pos = 0;
    end else begin
      pos++;
      if (pos == PER) begin
        pos = 0;
        for (int i = 0; i < CH; i++) begin
          if (!ramp_en)                m_cur[i] = m_tgt[i];
          else if (m_cur[i] < m_tgt[i]) m_cur[i]++;
          else if (m_cur[i] > m_tgt[i]) m_cur[i]--;
        end
      end
    end
    if (load)
      for (int i = 0; i < CH; i++) m_tgt[i] = int'(duty_target[i*W +: W]);
  endtask

  task automatic check_outputs();
    int b;
    b = 0;
    for (int i = 0; i < CH; i++) begin
      chk($sformatf("pwm%0d", i), int'(pwm_out[i]),
          (run && pos < m_cur[i] * PS) ? 1 : 0);
      if (m_cur[i] != m_tgt[i]) b = 1;
    end
    chk("period_start", int'(period_start), (run && pos == 0) ? 1 : 0);
    chk("busy", int'(busy), b);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run_n(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_load(input int d0, input int d1);
    logic [W-1:0] a, b;
    a = W'(d0);
    b = W'(d1);
    duty_target = {b, a};
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic run_to_pos(input int p);
    for (int k = 0; k < 2 * PER && !(run && pos == p); k++) step();
  endtask

  task automatic async_reset();
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_ps", int'(period_start), 0);
    chk("rst_busy", int'(busy), 0);
    run_n(2);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; ramp_en = 1'b0; duty_target = '0;
    model_reset();
    #1;
    chk("por_pwm", int'(pwm_out), 0);
    chk("por_busy", int'(busy), 0);
    run_n(3);
    rst = 1'b0;
    run_n(3);
    en = 1'b1;
    run_n(5);

    // ch0 off, ch1 full on
    do_load(0, 15);
    run_n(2 * PER);
    // jump to half duty
    do_load(8, 15);
    run_n(2 * PER);
    do_load(0, 15);
    run_n(PER + 5);

    // soft-start up then down
    ramp_en = 1'b1;
    do_load(15, 15);
    run_n(16 * PER);
    do_load(12, 15);
    run_n(4 * PER);

    // load mid-period, then a second load on the boundary clock
    ramp_en = 1'b0;
    run_to_pos(PER / 2);
    do_load(3, 15);
    run_to_pos(PER - 1);
    do_load(5, 15);
    run_n(2 * PER + 3);

    // reset in the middle of a ramp
    ramp_en = 1'b1;
    do_load(15, 0);
    run_n(2 * PER + PER / 3);
    async_reset();
    run_n(PER + 10);

    // randomized traffic: loads, ramp toggles, en toggles
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(99) < 2) begin
        duty_target = CH*W'($urandom);
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      if ($urandom_range(199) < 2) ramp_en = ~ramp_en;
      if ($urandom_range(999) < 3) en = ~en;
      if (!en && $urandom_range(99) < 5) en = 1'b1;
      step();
    end
    load = 1'b0;
    en = 1'b1;
    run_n(PER);
    async_reset();
    run_n(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
